// File: rtl/i2c_addr_matcher.sv
// I2C target address decoder: programmable table of 7/10-bit addresses, general call,
// and the 10-bit repeated-start read header. Tells the byte engine when to ACK and the direction.
module i2c_addr_matcher #(
  parameter int NUM_ADDR  = 2,
  parameter int ADDR10_EN = 1,
  parameter int GC_EN     = 1,
  localparam int IW = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scl_rise,
  input  logic                    sda_in,
  input  logic                    start_det,
  input  logic                    stop_det,
  input  logic [10*NUM_ADDR-1:0]  addr_table,
  input  logic [NUM_ADDR-1:0]     addr_mode,
  input  logic [NUM_ADDR-1:0]     addr_en,
  output logic                    ack_req,
  output logic                    addr_match,
  output logic [IW-1:0]           match_idx,
  output logic                    read_bit,
  output logic                    write_bit,
  output logic                    general_call,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR1, S_ACK1, S_ADDR2, S_ACK2, S_MATCHED, S_NOMATCH
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic              hold10_q, hold10_d;
  logic [IW-1:0]     hold_idx_q, hold_idx_d;
  logic [NUM_ADDR-1:0] cand_q, cand_d;
  logic [IW-1:0]     pend_idx_q, pend_idx_d;
  logic              pend_rw_q, pend_rw_d;
  logic              pend_gc_q, pend_gc_d;
  logic              pend_10_q, pend_10_d;
  logic              ack_req_q, ack_req_d;
  logic              addr_match_q, addr_match_d;
  logic [IW-1:0]     match_idx_q, match_idx_d;
  logic              read_bit_q, read_bit_d;
  logic              write_bit_q, write_bit_d;
  logic              general_call_q, general_call_d;

  logic [9:0]        ent [NUM_ADDR];
  logic [7:0]        byte_w;
  logic              m7_hit, m2_hit, hdr10;
  logic [IW-1:0]     m7_idx, m2_idx;
  logic [NUM_ADDR-1:0] hdr_cand;

  for (genvar g = 0; g < NUM_ADDR; g++) begin : g_ent
    assign ent[g] = addr_table[10*g +: 10];
  end

  // Byte as it stands once the current bit is shifted in; only meaningful on the 8th rise.
  assign byte_w = {shift_q, sda_in};
  assign hdr10  = (byte_w[7:3] == 5'b11110);

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    m7_hit   = 1'b0;
    m7_idx   = '0;
    m2_hit   = 1'b0;
    m2_idx   = '0;
    hdr_cand = '0;
    for (int i = NUM_ADDR - 1; i >= 0; i--) begin
      if (addr_en[i] && !addr_mode[i] && ent[i][6:0] == byte_w[7:1]) begin
        m7_hit = 1'b1;
        m7_idx = IW'(i);
      end
      hdr_cand[i] = addr_en[i] && addr_mode[i] && (ent[i][9:8] == byte_w[2:1]);
      if (cand_q[i] && ent[i][7:0] == byte_w) begin
        m2_hit = 1'b1;
        m2_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    hold10_d       = hold10_q;
    hold_idx_d     = hold_idx_q;
    cand_d         = cand_q;
    pend_idx_d     = pend_idx_q;
    pend_rw_d      = pend_rw_q;
    pend_gc_d      = pend_gc_q;
    pend_10_d      = pend_10_q;
    ack_req_d      = ack_req_q;
    addr_match_d   = addr_match_q;
    match_idx_d    = match_idx_q;
    read_bit_d     = read_bit_q;
    write_bit_d    = write_bit_q;
    general_call_d = general_call_q;

    if (stop_det) begin
      state_d        = S_IDLE;
      bit_cnt_d      = '0;
      shift_d        = '0;
      hold10_d       = 1'b0;
      ack_req_d      = 1'b0;
      addr_match_d   = 1'b0;
      match_idx_d    = '0;
      read_bit_d     = 1'b0;
      write_bit_d    = 1'b0;
      general_call_d = 1'b0;
    end else if (start_det) begin
      // hold10 survives so a repeated-start read header can reach the held entry.
      state_d        = S_ADDR1;
      bit_cnt_d      = '0;
      shift_d        = '0;
      ack_req_d      = 1'b0;
      addr_match_d   = 1'b0;
      match_idx_d    = '0;
      read_bit_d     = 1'b0;
      write_bit_d    = 1'b0;
      general_call_d = 1'b0;
    end else if (scl_rise) begin
      unique case (state_q)
        S_ADDR1, S_ADDR2: begin
          shift_d   = byte_w[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d   = S_NOMATCH;
            pend_gc_d = 1'b0;
            pend_10_d = 1'b0;
            pend_rw_d = 1'b0;
            if (state_q == S_ADDR1) begin
              hold10_d = 1'b0;
              if (m7_hit) begin
                state_d    = S_ACK1;
                ack_req_d  = 1'b1;
                pend_idx_d = m7_idx;
                pend_rw_d  = byte_w[0];
              end else if (GC_EN != 0 && byte_w == 8'h00) begin
                state_d    = S_ACK1;
                ack_req_d  = 1'b1;
                pend_idx_d = '0;
                pend_gc_d  = 1'b1;
              end else if (ADDR10_EN != 0 && hdr10 && !byte_w[0] && |hdr_cand) begin
                state_d   = S_ACK1;
                ack_req_d = 1'b1;
                pend_10_d = 1'b1;
                cand_d    = hdr_cand;
              end else if (ADDR10_EN != 0 && hdr10 && byte_w[0] && hold10_q &&
                           ent[hold_idx_q][9:8] == byte_w[2:1]) begin
                state_d    = S_ACK1;
                ack_req_d  = 1'b1;
                pend_idx_d = hold_idx_q;
                pend_rw_d  = 1'b1;
                hold10_d   = 1'b1;
              end
            end else if (m2_hit) begin
              state_d    = S_ACK2;
              ack_req_d  = 1'b1;
              pend_idx_d = m2_idx;
              hold10_d   = 1'b1;
              hold_idx_d = m2_idx;
            end
          end
        end
        S_ACK1, S_ACK2: begin
          ack_req_d = 1'b0;
          bit_cnt_d = '0;
          if (state_q == S_ACK1 && pend_10_q) begin
            state_d = S_ADDR2;
          end else begin
            state_d        = S_MATCHED;
            addr_match_d   = 1'b1;
            match_idx_d    = pend_idx_q;
            read_bit_d     = pend_rw_q;
            write_bit_d    = !pend_rw_q;
            general_call_d = pend_gc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      hold10_q       <= 1'b0;
      hold_idx_q     <= '0;
      cand_q         <= '0;
      pend_idx_q     <= '0;
      pend_rw_q      <= 1'b0;
      pend_gc_q      <= 1'b0;
      pend_10_q      <= 1'b0;
      ack_req_q      <= 1'b0;
      addr_match_q   <= 1'b0;
      match_idx_q    <= '0;
      read_bit_q     <= 1'b0;
      write_bit_q    <= 1'b0;
      general_call_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      hold10_q       <= hold10_d;
      hold_idx_q     <= hold_idx_d;
      cand_q         <= cand_d;
      pend_idx_q     <= pend_idx_d;
      pend_rw_q      <= pend_rw_d;
      pend_gc_q      <= pend_gc_d;
      pend_10_q      <= pend_10_d;
      ack_req_q      <= ack_req_d;
      addr_match_q   <= addr_match_d;
      match_idx_q    <= match_idx_d;
      read_bit_q     <= read_bit_d;
      write_bit_q    <= write_bit_d;
      general_call_q <= general_call_d;
    end
  end

  assign ack_req      = ack_req_q;
  assign addr_match   = addr_match_q;
  assign match_idx    = match_idx_q;
  assign read_bit     = read_bit_q;
  assign write_bit    = write_bit_q;
  assign general_call = general_call_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_addr_matcher.sv
// Directed bench for i2c_addr_matcher: two instances (general call on / off) share one bus;
// expected output vectors are queued as stimulus is driven and checked once it has been applied.
module tb_i2c_addr_matcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_rise = 1'b0, sda_in = 1'b0, start_det = 1'b0, stop_det = 1'b0;
  logic [19:0] addr_table = {10'h066, 10'h2A5};
  logic [1:0] addr_mode = 2'b01;
  logic [1:0] addr_en = 2'b11;

  logic       ack0, match0, idx0, rd0, wr0, gc0, busy0;
  logic       ack1, match1, idx1, rd1, wr1, gc1, busy1;
  logic [6:0] obs0, obs1;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [7:0] sb_q[$];
  string      tag_q[$];

  // Expected vectors: {ack_req, addr_match, match_idx, read_bit, write_bit, general_call, busy}
  localparam logic [6:0] E_IDLE = 7'b0000000;
  localparam logic [6:0] E_BUSY = 7'b0000001;
  localparam logic [6:0] E_ACK  = 7'b1000001;
  localparam logic [6:0] M_W1   = 7'b0110101;
  localparam logic [6:0] M_W0   = 7'b0100101;
  localparam logic [6:0] M_R0   = 7'b0101001;
  localparam logic [6:0] M_R1   = 7'b0111001;
  localparam logic [6:0] M_GC   = 7'b0100111;

  i2c_addr_matcher #(.NUM_ADDR(2), .ADDR10_EN(1), .GC_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .scl_rise(scl_rise), .sda_in(sda_in),
    .start_det(start_det), .stop_det(stop_det), .addr_table(addr_table),
    .addr_mode(addr_mode), .addr_en(addr_en), .ack_req(ack0), .addr_match(match0),
    .match_idx(idx0), .read_bit(rd0), .write_bit(wr0), .general_call(gc0), .busy(busy0));

  i2c_addr_matcher #(.NUM_ADDR(2), .ADDR10_EN(1), .GC_EN(0)) dut_nogc (
    .clk(clk), .rst_n(rst_n), .scl_rise(scl_rise), .sda_in(sda_in),
    .start_det(start_det), .stop_det(stop_det), .addr_table(addr_table),
    .addr_mode(addr_mode), .addr_en(addr_en), .ack_req(ack1), .addr_match(match1),
    .match_idx(idx1), .read_bit(rd1), .write_bit(wr1), .general_call(gc1), .busy(busy1));

  assign obs0 = {ack0, match0, idx0, rd0, wr0, gc0, busy0};
  assign obs1 = {ack1, match1, idx1, rd1, wr1, gc1, busy1};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string tag, logic sel, logic [6:0] v);
    sb_q.push_back({sel, v});
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    logic [7:0] e;
    logic [6:0] o;
    string t;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      o = e[7] ? obs1 : obs0;
      vec_cnt++;
      assert (o === e[6:0]) else begin
        err_cnt++;
        $error("FAIL %s: observed %b expected %b", t, o, e[6:0]);
      end
    end
  endtask

  task automatic rise(logic b);
    sda_in = b; scl_rise = 1'b1;
    tick();
    scl_rise = 1'b0;
    tick();
  endtask

  task automatic step_bit(logic b, string tag, logic [6:0] v);
    push(tag, 1'b0, v);
    rise(b);
    drain();
  endtask

  task automatic step_byte(logic [7:0] b, string tag, logic [6:0] v);
    push(tag, 1'b0, v);
    for (int i = 7; i >= 0; i--) rise(b[i]);
    drain();
  endtask

  task automatic step_start(string tag, logic [6:0] v);
    push(tag, 1'b0, v);
    start_det = 1'b1;
    tick();
    start_det = 1'b0;
    drain();
  endtask

  task automatic step_stop(string tag, logic [6:0] v);
    push(tag, 1'b0, v);
    stop_det = 1'b1;
    tick();
    stop_det = 1'b0;
    drain();
  endtask

  initial begin
    // Reset
    push("reset", 1'b0, E_IDLE);
    push("reset_nogc", 1'b1, E_IDLE);
    repeat (3) tick();
    drain();
    rst_n = 1'b1;
    tick();

    // 7-bit write to entry 1 (0x66)
    step_start("a_start", E_BUSY);
    push("a_ack_nogc", 1'b1, E_ACK);
    step_byte(8'hCC, "a_ack", E_ACK);
    step_bit(1'b0, "a_match", M_W1);
    step_bit(1'b1, "a_hold", M_W1);
    step_stop("a_stop", E_IDLE);

    // 10-bit write to entry 0 (0x2A5), then repeated-start read
    step_start("t_start", E_BUSY);
    step_byte(8'hF4, "t_hdr_ack", E_ACK);
    step_bit(1'b0, "t_hdr_9th", E_BUSY);
    step_byte(8'hA5, "t_lo_ack", E_ACK);
    step_bit(1'b0, "t_wr_match", M_W0);
    step_start("t_rstart", E_BUSY);
    step_byte(8'hF5, "t_rd_ack", E_ACK);
    step_bit(1'b0, "t_rd_match", M_R0);
    step_stop("t_stop", E_IDLE);

    // STOP between 10-bit write and read drops the held entry
    step_start("s_start", E_BUSY);
    step_byte(8'hF4, "s_hdr_ack", E_ACK);
    step_bit(1'b0, "s_hdr_9th", E_BUSY);
    step_byte(8'hA5, "s_lo_ack", E_ACK);
    step_bit(1'b0, "s_wr_match", M_W0);
    step_stop("s_stop", E_IDLE);
    step_start("s_start2", E_BUSY);
    step_byte(8'hF5, "s_rd_nack", E_BUSY);
    step_bit(1'b0, "s_rd_nomatch", E_BUSY);
    step_stop("s_stop2", E_IDLE);

    // General call: acked with GC_EN=1, nacked with GC_EN=0
    step_start("g_start", E_BUSY);
    push("g_nack_nogc", 1'b1, E_BUSY);
    step_byte(8'h00, "g_ack", E_ACK);
    push("g_nomatch_nogc", 1'b1, E_BUSY);
    step_bit(1'b0, "g_match", M_GC);
    step_stop("g_stop", E_IDLE);

    // Unknown address, then repeated-start 7-bit read; table edits don't disturb the match
    step_start("u_start", E_BUSY);
    step_byte(8'hCE, "u_nack", E_BUSY);
    step_bit(1'b0, "u_nomatch", E_BUSY);
    step_start("u_rstart", E_BUSY);
    step_byte(8'hCD, "u_rd_ack", E_ACK);
    step_bit(1'b0, "u_rd_match", M_R1);
    addr_en = 2'b00;
    addr_table = 20'h0;
    step_bit(1'b1, "u_tbl_change", M_R1);
    addr_en = 2'b11;
    addr_table = {10'h066, 10'h2A5};
    step_stop("u_stop", E_IDLE);

    // STOP mid-byte, then START with a coincident SCL rise (bit must be dropped)
    step_start("m_start", E_BUSY);
    for (int i = 0; i < 4; i++) rise(1'b1);
    step_stop("m_stop_mid", E_IDLE);
    push("m_start_rise", 1'b0, E_BUSY);
    start_det = 1'b1; scl_rise = 1'b1; sda_in = 1'b1;
    tick();
    start_det = 1'b0; scl_rise = 1'b0;
    tick();
    drain();
    step_byte(8'hCC, "m_ack", E_ACK);
    step_bit(1'b0, "m_match", M_W1);

    // Asynchronous reset while matched
    push("r_async", 1'b0, E_IDLE);
    push("r_async_nogc", 1'b1, E_IDLE);
    #2 rst_n = 1'b0;
    #1;
    drain();
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_addr_matcher.md
Name: i2c_addr_matcher

Overview:
Parametrised I2C target address decoder that replaces the fixed single 7-bit checker. It supports a table of NUM_ADDR programmable addresses, each configurable as 7-bit or 10-bit. It also supports general-call detection and the 10-bit repeated-start read sequence. It sits between the bus front-end (edge/START/STOP detection) and the byte engine, and tells the byte engine when to ACK and in which direction to run.

Parameters:
NUM_ADDR, 2, number of address table entries (1..8)
ADDR10_EN, 1, 1 = 10-bit address decoding present; 0 = 10-bit headers always NACKed
GC_EN, 1, 1 = general call (0x00) matched

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
scl_rise  input  1  one-clk strobe per SCL rising edge (synchronised upstream)
sda_in  input  1  synchronised SDA, valid when scl_rise=1
start_det  input  1  one-clk strobe: START or repeated START
stop_det  input  1  one-clk strobe: STOP
addr_table  input  10*NUM_ADDR  entry i at [10i+9:10i]; 7-bit entries use [6:0]
addr_mode  input  NUM_ADDR  1 = entry i is 10-bit
addr_en  input  NUM_ADDR  1 = entry i enabled
ack_req  output  1  drive ACK (SDA low) during the current 9th bit
addr_match  output  1  level: addressed, data phase active
match_idx  output  max(1,$clog2(NUM_ADDR))  matched entry index
read_bit  output  1  matched, target transmits
write_bit  output  1  matched, target receives
general_call  output  1  match was general call
busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE, bit_cnt=0, shift=0, hold10=0. All outputs 0, match_idx=0.
- States: IDLE, ADDR1, ACK1, ADDR2, ACK2, MATCHED, NOMATCH.
- Priority per clk: stop_det > start_det > scl_rise.
  - stop_det: -> IDLE; clear all outputs and hold10.
  - start_det (any state): -> ADDR1; bit_cnt=0; clear addr_match, read_bit, write_bit, general_call and ack_req.
  - A scl_rise coincident with start_det or stop_det is discarded.
- ADDR1/ADDR2: on each scl_rise, shift in sda_in MSB first and increment bit_cnt. The 8th scl_rise completes byte b, and the decision is registered on that same clk edge using the current table inputs.
- ADDR1 decision (lowest matching index wins):
  - 7-bit entry i, addr_en[i]=1, addr_mode[i]=0, entry[6:0]==b[7:1] -> ACK1, pending match, rw=b[0].
  - GC_EN=1 and b==8'h00 -> ACK1, pending general call (write).
  - b[7:3]==5'b11110, ADDR10_EN=1, rw=0, some enabled 10-bit entry with entry[9:8]==b[2:1] -> ACK1, then ADDR2. Candidate set is latched.
  - b[7:3]==5'b11110, rw=1, hold10=1, held entry[9:8]==b[2:1] -> ACK1, pending read match of held index.
  - Otherwise -> NOMATCH; ack_req stays 0.
- ACK1/ACK2:
  - ack_req=1 from the clk after the 8th scl_rise until the 9th scl_rise.
  - On the 9th scl_rise: ack_req=0, bit_cnt=0, go to MATCHED, or to ADDR2 from ACK1 for a 10-bit first byte.
  - addr_match, read_bit/write_bit, match_idx and general_call assert on the 9th scl_rise clk (1-clk registered latency) and are mutually consistent.
  - read_bit and write_bit are never both 1.
- ADDR2: 8th scl_rise compares b with entry[7:0] of the latched candidates, lowest index wins.
  - Match -> ACK2, pending write match; set hold10=1 and held index.
  - Miss -> NOMATCH.
- MATCHED: outputs held, scl_rise ignored until start_det/stop_det.
- hold10:
  - Cleared by stop_det, by any ADDR1 decision other than the 10-bit read-header match, and by reset.
  - Kept across a repeated start.
- NOMATCH: ignore bus until start_det/stop_det; all outputs 0 except busy.
- Table or enable changes take effect at the next decision clk; changes never alter an established match.
- Reset mid-transaction: immediate return to reset values.
- NUM_ADDR=1: match_idx is 1 bit, always 0.

Test Plan:
- Entry1=7'h66 (7-bit, en): START, byte 0xCC -> ack_req high after bit 8; addr_match=1, write_bit=1, match_idx=1 on 9th rise.
- Entry0=10'h2A5 (10-bit): START, 0xF4, 0xA5 -> two ACKs, write_bit=1, hold10=1. Repeated START, 0xF5 -> ACK, read_bit=1, match_idx=0.
- STOP between the 10-bit write and the read, then START, 0xF5 -> NOMATCH, no ack_req, addr_match=0.
- GC_EN=1: START, 0x00 -> ACK, general_call=1, write_bit=1. Rerun with GC_EN=0 -> NACK.
- START, 0xCE (unknown) -> NOMATCH, no ACK. Then repeated START, 0xCD -> read match, read_bit=1.
- Mid-byte: stop_det after 4 bits -> IDLE, busy=0. Then start_det with scl_rise in the same clk -> bit discarded, bit_cnt=0. Reset asserted while MATCHED -> all outputs 0.
